// File: rtl/driver_row_scanner.sv
// rtl/driver_row_scanner.sv - 5-row LED matrix scanner with double-buffered frame store; optional blanking via DRIVER_ROW_SCANNER_BLANK_EN
module driver_row_scanner #(
  parameter int COLS         = 7,
  parameter int BLANK_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      row_idx,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            commit,
  output logic [4:0]      row_sel,
  output logic [COLS-1:0] col_out,
  output logic            frame_start,
  output logic            swap_pending,
  output logic            idx_err
);

  localparam int NROWS = 5;

  logic [2:0]      idx_q, idx_d;
  logic [COLS-1:0] buf_a_q [NROWS];
  logic [COLS-1:0] buf_a_d [NROWS];
  logic [COLS-1:0] buf_b_q [NROWS];
  logic [COLS-1:0] buf_b_d [NROWS];
  logic            front_b_q, front_b_d;
  logic            swap_pending_q, swap_pending_d;
  logic            frame_start_q, frame_start_d;
  logic            idx_err_q, idx_err_d;
  logic [4:0]      row_sel_q, row_sel_d;
  logic [COLS-1:0] col_out_q, col_out_d;

  logic            idx_legal;
  logic            row_change;
  logic            boundary;
  logic            do_swap;
  logic [COLS-1:0] row_data;
  logic            show_next;

  // Index tracking, frame boundary detection and swap bookkeeping
  always_comb begin
    idx_d          = row_idx;
    idx_legal      = (row_idx <= 3'd4);
    row_change     = (row_idx != idx_q);
    boundary       = (idx_q == 3'd4) && (row_idx == 3'd0);
    do_swap        = boundary && (swap_pending_q || commit);
    front_b_d      = front_b_q ^ do_swap;
    swap_pending_d = boundary ? 1'b0 : (swap_pending_q || commit);
    frame_start_d  = boundary;
    idx_err_d      = idx_err_q || !idx_legal;
  end

  // Back-buffer writes always target the pre-swap back buffer
  always_comb begin
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    for (int r = 0; r < NROWS; r++) begin
      if (wr_en && (wr_row == 3'(r))) begin
        if (front_b_q) buf_a_d[r] = wr_data;
        else           buf_b_d[r] = wr_data;
      end
    end
  end

  // Read the row from the next-state front so a boundary swap (and a write on that edge) shows at once
  always_comb begin
    row_data = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (row_idx == 3'(r)) row_data = front_b_d ? buf_b_d[r] : buf_a_d[r];
    end
  end

`ifdef DRIVER_ROW_SCANNER_BLANK_EN
  localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_t;

  scan_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Blanking sequencer: every row change restarts the blank window
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SHOW: begin
        if (row_change && (BLANK_CYCLES > 0)) begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_LOAD;
        end
      end
      ST_BLANK: begin
        if (row_change) begin
          cnt_d = BLANK_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_SHOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end
    endcase
    show_next = (state_d == ST_SHOW);
  end

  // Blanking state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SHOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_blank_cfg;
  assign unused_blank_cfg = (BLANK_CYCLES != 0);

  // No blanking: every row is driven on the edge that samples it
  always_comb begin
    show_next = 1'b1;
  end
`endif

  // Output drive: selected row when showing a legal index, otherwise dark
  always_comb begin
    row_sel_d = '0;
    col_out_d = '0;
    if (show_next && idx_legal) begin
      row_sel_d = 5'b00001 << row_idx;
      col_out_d = row_data;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q          <= '0;
      front_b_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_start_q  <= 1'b0;
      idx_err_q      <= 1'b0;
      row_sel_q      <= '0;
      col_out_q      <= '0;
      for (int r = 0; r < NROWS; r++) begin
        buf_a_q[r] <= '0;
        buf_b_q[r] <= '0;
      end
    end else begin
      idx_q          <= idx_d;
      front_b_q      <= front_b_d;
      swap_pending_q <= swap_pending_d;
      frame_start_q  <= frame_start_d;
      idx_err_q      <= idx_err_d;
      row_sel_q      <= row_sel_d;
      col_out_q      <= col_out_d;
      buf_a_q        <= buf_a_d;
      buf_b_q        <= buf_b_d;
    end
  end

  assign row_sel      = row_sel_q;
  assign col_out      = col_out_q;
  assign frame_start  = frame_start_q;
  assign swap_pending = swap_pending_q;
  assign idx_err      = idx_err_q;

endmodule

// File: tb/tb_driver_row_scanner.sv
// tb/tb_driver_row_scanner.sv - directed table-driven bench for driver_row_scanner
module tb_driver_row_scanner;

`ifdef DRIVER_ROW_SCANNER_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] row_idx;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [6:0] wr_data;
  logic       commit;
  logic [4:0] row_sel;
  logic [6:0] col_out;
  logic       frame_start;
  logic       swap_pending;
  logic       idx_err;

  int checks;
  int errors;

  driver_row_scanner #(.COLS(7), .BLANK_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row_idx      (row_idx),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .commit       (commit),
    .row_sel      (row_sel),
    .col_out      (col_out),
    .frame_start  (frame_start),
    .swap_pending (swap_pending),
    .idx_err      (idx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic       we;
    logic [2:0] wr;
    logic [6:0] wd;
    logic       cm;
    logic [4:0] sel;
    logic [6:0] col;
    logic       fs;
    logic       sp;
    logic       err;
    logic       bz;   // row_sel/col_out are dark here when blanking is built in
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] idx, input logic we, input logic [2:0] wr,
                     input logic [6:0] wd, input logic cm, input logic [4:0] sel,
                     input logic [6:0] col, input logic fs, input logic sp,
                     input logic err, input logic bz);
    vec_t v;
    v.idx = idx; v.we = we; v.wr = wr; v.wd = wd; v.cm = cm;
    v.sel = sel; v.col = col; v.fs = fs; v.sp = sp; v.err = err; v.bz = bz;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle(input logic [2:0] idx);
    row_idx = idx; wr_en = 1'b0; wr_row = 3'd0; wr_data = 7'h00; commit = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_idle(3'd0);

    //   idx  we wr  wd    cm  sel       col    fs sp er bz
    add(3'd0, 0, 0, 7'h00, 0, 5'b00001, 7'h00, 0, 0, 0, 0);
    add(3'd0, 1, 2, 7'h55, 0, 5'b00001, 7'h00, 0, 0, 0, 0);
    add(3'd1, 0, 0, 7'h00, 0, 5'b00010, 7'h00, 0, 0, 0, 1);
    add(3'd1, 0, 0, 7'h00, 1, 5'b00010, 7'h00, 0, 1, 0, 1);
    add(3'd1, 0, 0, 7'h00, 0, 5'b00010, 7'h00, 0, 1, 0, 0);
    add(3'd2, 0, 0, 7'h00, 0, 5'b00100, 7'h00, 0, 1, 0, 1);
    add(3'd2, 0, 0, 7'h00, 1, 5'b00100, 7'h00, 0, 1, 0, 1);
    add(3'd2, 0, 0, 7'h00, 0, 5'b00100, 7'h00, 0, 1, 0, 0);
    add(3'd3, 0, 0, 7'h00, 0, 5'b01000, 7'h00, 0, 1, 0, 1);
    add(3'd4, 0, 0, 7'h00, 0, 5'b10000, 7'h00, 0, 1, 0, 1);
    add(3'd4, 0, 0, 7'h00, 0, 5'b10000, 7'h00, 0, 1, 0, 1);
    add(3'd4, 0, 0, 7'h00, 0, 5'b10000, 7'h00, 0, 1, 0, 0);
    add(3'd0, 0, 0, 7'h00, 0, 5'b00001, 7'h00, 1, 0, 0, 1);
    add(3'd0, 0, 0, 7'h00, 0, 5'b00001, 7'h00, 0, 0, 0, 1);
    add(3'd0, 0, 0, 7'h00, 0, 5'b00001, 7'h00, 0, 0, 0, 0);
    add(3'd2, 0, 0, 7'h00, 0, 5'b00100, 7'h55, 0, 0, 0, 1);
    add(3'd2, 0, 0, 7'h00, 0, 5'b00100, 7'h55, 0, 0, 0, 1);
    add(3'd2, 0, 0, 7'h00, 0, 5'b00100, 7'h55, 0, 0, 0, 0);
    add(3'd4, 0, 0, 7'h00, 0, 5'b10000, 7'h00, 0, 0, 0, 1);
    add(3'd4, 0, 0, 7'h00, 0, 5'b10000, 7'h00, 0, 0, 0, 1);
    add(3'd4, 0, 0, 7'h00, 0, 5'b10000, 7'h00, 0, 0, 0, 0);
    add(3'd0, 1, 0, 7'h7F, 1, 5'b00001, 7'h7F, 1, 0, 0, 1);
    add(3'd0, 0, 0, 7'h00, 0, 5'b00001, 7'h7F, 0, 0, 0, 1);
    add(3'd0, 0, 0, 7'h00, 0, 5'b00001, 7'h7F, 0, 0, 0, 0);
    add(3'd0, 1, 0, 7'h01, 0, 5'b00001, 7'h7F, 0, 0, 0, 0);
    add(3'd0, 1, 6, 7'h33, 0, 5'b00001, 7'h7F, 0, 0, 0, 0);
    add(3'd6, 0, 0, 7'h00, 0, 5'b00000, 7'h00, 0, 0, 1, 0);
    add(3'd2, 0, 0, 7'h00, 0, 5'b00100, 7'h00, 0, 0, 1, 1);
    add(3'd2, 0, 0, 7'h00, 0, 5'b00100, 7'h00, 0, 0, 1, 1);
    add(3'd2, 0, 0, 7'h00, 0, 5'b00100, 7'h00, 0, 0, 1, 0);

    // Reset state
    @(posedge clk); #1;
    chk("reset_row_sel", row_sel, 0);
    chk("reset_col_out", col_out, 0);
    chk("reset_frame_start", frame_start, 0);
    chk("reset_swap_pending", swap_pending, 0);
    chk("reset_idx_err", idx_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      row_idx = vecs[i].idx; wr_en = vecs[i].we; wr_row = vecs[i].wr;
      wr_data = vecs[i].wd;  commit = vecs[i].cm;
      @(posedge clk); #1;
      chk($sformatf("v%0d_row_sel", i), row_sel, (BLANK_ON && vecs[i].bz) ? 0 : int'(vecs[i].sel));
      chk($sformatf("v%0d_col_out", i), col_out, (BLANK_ON && vecs[i].bz) ? 0 : int'(vecs[i].col));
      chk($sformatf("v%0d_frame_start", i), frame_start, vecs[i].fs);
      chk($sformatf("v%0d_swap_pending", i), swap_pending, vecs[i].sp);
      chk($sformatf("v%0d_idx_err", i), idx_err, vecs[i].err);
    end

    // Mid-scan asynchronous reset while row 3 is showing with a swap pending
    @(negedge clk);
    drive_idle(3'd3);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    repeat (3) @(negedge clk);
    chk("midscan_row3", row_sel, 5'b01000);
    chk("midscan_pending", swap_pending, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_row_sel", row_sel, 0);
    chk("async_rst_col_out", col_out, 0);
    chk("async_rst_swap_pending", swap_pending, 0);
    chk("async_rst_idx_err", idx_err, 0);
    chk("async_rst_frame_start", frame_start, 0);
    drive_idle(3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_row_sel", row_sel, 5'b00001);
    chk("post_rst_col_cleared", col_out, 0);

    // Row index toggling 3/4 every cycle
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      row_idx = (k % 2 == 0) ? 3'd3 : 3'd4;
      @(posedge clk); #1;
      chk($sformatf("toggle%0d_row_sel", k), row_sel,
          BLANK_ON ? 0 : ((k % 2 == 0) ? 5'b01000 : 5'b10000));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
